// File: rtl/m92_pkg.sv
// Shared constants and types for the M92 main/sound CPU mailbox.
package m92_pkg;

  localparam logic [7:0] SND_CMD_IO   = 8'h00;
  localparam logic [7:0] SND_REPLY_IO = 8'h08;
  localparam int         INT_SOUND    = 3;

  typedef struct packed {
    logic overrun;
    logic reply_pending;
    logic cmd_pending;
  } snd_status_t;

endpackage

// File: rtl/m92_strobe_edge.sv
// Registered rising-edge detector; clr forces the history low and masks the edge.
module m92_strobe_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic strobe,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = clr ? 1'b0 : strobe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise = strobe & ~prev_q & ~clr;

endmodule

// File: rtl/m92_sound_comm.sv
// Command/reply mailbox between the M92 V30 and the sound CPU, with the
// sound-side command interrupt and the main-side reply interrupt.
module m92_sound_comm
  import m92_pkg::*;
#(
  parameter int LATCH_W      = 16,
  parameter bit REPLY_IRQ_EN = 1'b1
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               main_wr,
  input  logic [1:0]         main_be,
  input  logic [LATCH_W-1:0] main_din,
  input  logic               main_rd,
  output logic [LATCH_W-1:0] main_dout,
  output logic               main_irq,
  output logic [2:0]         main_status,
  input  logic               snd_reset_n,
  input  logic               snd_rd,
  output logic [LATCH_W-1:0] snd_dout,
  input  logic               snd_wr,
  input  logic [LATCH_W-1:0] snd_din,
  output logic               snd_irq,
  input  logic               snd_irq_ack
);

  logic main_wr_rise, main_rd_rise, snd_rd_rise, snd_wr_rise, snd_ack_rise;
  logic snd_clr;

  assign snd_clr = ~snd_reset_n;

  m92_strobe_edge u_main_wr (.clk(clk_sys), .rst_n(reset_n), .clr(1'b0),    .strobe(main_wr),     .rise(main_wr_rise));
  m92_strobe_edge u_main_rd (.clk(clk_sys), .rst_n(reset_n), .clr(1'b0),    .strobe(main_rd),     .rise(main_rd_rise));
  m92_strobe_edge u_snd_rd  (.clk(clk_sys), .rst_n(reset_n), .clr(snd_clr), .strobe(snd_rd),      .rise(snd_rd_rise));
  m92_strobe_edge u_snd_wr  (.clk(clk_sys), .rst_n(reset_n), .clr(snd_clr), .strobe(snd_wr),      .rise(snd_wr_rise));
  m92_strobe_edge u_snd_ack (.clk(clk_sys), .rst_n(reset_n), .clr(snd_clr), .strobe(snd_irq_ack), .rise(snd_ack_rise));

  logic [LATCH_W-1:0] cmd_q, cmd_d, reply_q, reply_d, defer_data_q, defer_data_d;
  logic [1:0]         defer_be_q, defer_be_d;
  logic               cmd_pending_q, cmd_pending_d, reply_pending_q, reply_pending_d;
  logic               overrun_q, overrun_d, snd_irq_q, snd_irq_d, defer_q, defer_d;
  snd_status_t        status;

  // Byte-lane merge: be[0] covers bits 7:0, be[1] everything above.
  function automatic logic [LATCH_W-1:0] merge_bytes(input logic [LATCH_W-1:0] old_v,
                                                     input logic [LATCH_W-1:0] new_v,
                                                     input logic [1:0]         be);
    logic [LATCH_W-1:0] res;
    for (int b = 0; b < LATCH_W; b++) begin
      res[b] = ((b < 8) ? be[0] : be[1]) ? new_v[b] : old_v[b];
    end
    return res;
  endfunction

  always_comb begin
    cmd_d           = cmd_q;
    reply_d         = reply_q;
    defer_data_d    = defer_data_q;
    defer_be_d      = defer_be_q;
    defer_d         = defer_q;
    cmd_pending_d   = cmd_pending_q;
    reply_pending_d = reply_pending_q;
    overrun_d       = overrun_q;
    snd_irq_d       = snd_irq_q;

    if (main_rd_rise) begin
      reply_pending_d = 1'b0;
      overrun_d       = 1'b0;
    end
    if (snd_wr_rise) begin
      reply_d         = snd_din;
      reply_pending_d = 1'b1;
    end

    if (!snd_reset_n) begin
      cmd_pending_d = 1'b0;
      snd_irq_d     = 1'b0;
      if (main_wr_rise) begin
        defer_d      = 1'b1;
        defer_data_d = merge_bytes(defer_data_q, main_din, main_be);
        defer_be_d   = defer_be_q | main_be;
      end
    end else begin
      if (snd_rd_rise || snd_ack_rise) snd_irq_d = 1'b0;
      if (snd_rd_rise) cmd_pending_d = 1'b0;
      // A write held back during sound reset lands on the first cycle out of it.
      if (defer_q) begin
        cmd_d         = merge_bytes(cmd_q, defer_data_q, defer_be_q);
        cmd_pending_d = 1'b1;
        snd_irq_d     = 1'b1;
        defer_d       = 1'b0;
        defer_be_d    = 2'b00;
      end
      if (main_wr_rise) begin
        if ((cmd_pending_q && !snd_rd_rise) || defer_q) overrun_d = 1'b1;
        cmd_d         = merge_bytes(cmd_d, main_din, main_be);
        cmd_pending_d = 1'b1;
        snd_irq_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q           <= '0;
      reply_q         <= '0;
      defer_data_q    <= '0;
      defer_be_q      <= 2'b00;
      defer_q         <= 1'b0;
      cmd_pending_q   <= 1'b0;
      reply_pending_q <= 1'b0;
      overrun_q       <= 1'b0;
      snd_irq_q       <= 1'b0;
    end else begin
      cmd_q           <= cmd_d;
      reply_q         <= reply_d;
      defer_data_q    <= defer_data_d;
      defer_be_q      <= defer_be_d;
      defer_q         <= defer_d;
      cmd_pending_q   <= cmd_pending_d;
      reply_pending_q <= reply_pending_d;
      overrun_q       <= overrun_d;
      snd_irq_q       <= snd_irq_d;
    end
  end

  always_comb begin
    status.overrun       = overrun_q;
    status.reply_pending = reply_pending_q;
    status.cmd_pending   = cmd_pending_q;
  end

  assign main_status = status;
  assign main_dout   = reply_q;
  assign snd_dout    = cmd_q;
  assign snd_irq     = snd_irq_q;
  assign main_irq    = reply_pending_q & REPLY_IRQ_EN;

endmodule

// File: tb/tb_m92_sound_comm.sv
// Directed scoreboard bench for the M92 sound mailbox.
module tb_m92_sound_comm;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        main_wr, main_rd, snd_reset_n, snd_rd, snd_wr, snd_irq_ack;
  logic [1:0]  main_be;
  logic [15:0] main_din, snd_din;
  logic [15:0] main_dout, snd_dout;
  logic        main_irq, snd_irq;
  logic [2:0]  main_status;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int vectorsApplied = 0;
  int miscompares    = 0;

  always #5 clk_sys = ~clk_sys;

  m92_sound_comm dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .main_wr(main_wr), .main_be(main_be), .main_din(main_din),
    .main_rd(main_rd), .main_dout(main_dout), .main_irq(main_irq),
    .main_status(main_status), .snd_reset_n(snd_reset_n),
    .snd_rd(snd_rd), .snd_dout(snd_dout), .snd_wr(snd_wr),
    .snd_din(snd_din), .snd_irq(snd_irq), .snd_irq_ack(snd_irq_ack)
  );

  task automatic applyStimulus(input logic wr, input logic [1:0] be, input logic [15:0] din,
                               input logic rd, input logic srd, input logic swr,
                               input logic [15:0] sdin, input logic ack);
    main_wr = wr; main_be = be; main_din = din; main_rd = rd;
    snd_rd = srd; snd_wr = swr; snd_din = sdin; snd_irq_ack = ack;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic expectVal(input string tag, input logic [15:0] v);
    sb_item_t it;
    it.tag = tag;
    it.exp = v;
    sb.push_back(it);
  endtask

  task automatic checkOutput(input logic [15:0] observed);
    sb_item_t it;
    vectorsApplied++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty observed=%0h", observed);
      return;
    end
    it = sb.pop_front();
    assert (observed === it.exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", it.tag, observed, it.exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
    end
  endtask

  function automatic logic [15:0] st(input logic [2:0] s);
    return {13'b0, s};
  endfunction

  function automatic logic [15:0] b1(input logic s);
    return {15'b0, s};
  endfunction

  initial begin
    reset_n = 1'b0;
    snd_reset_n = 1'b1;
    idle();
    step(2);
    expectVal("rst_status", 16'h0000);  checkOutput(st(main_status));
    expectVal("rst_snd_dout", 16'h0000); checkOutput(snd_dout);
    expectVal("rst_main_dout", 16'h0000); checkOutput(main_dout);
    expectVal("rst_irqs", 16'h0000);    checkOutput({14'b0, main_irq, snd_irq});
    reset_n = 1'b1;
    step(1);

    // Held write: acts once, latch visible after the edge cycle.
    applyStimulus(1'b1, 2'b11, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    expectVal("wr_old_value", 16'h0000); checkOutput(snd_dout);
    step(1);
    expectVal("wr_latch", 16'h1234);    checkOutput(snd_dout);
    expectVal("wr_snd_irq", 16'h0001);  checkOutput(b1(snd_irq));
    expectVal("wr_status", 16'h0001);   checkOutput(st(main_status));
    step(3);
    expectVal("wr_held_once", 16'h0001); checkOutput(st(main_status));
    idle(); step(1);

    // Upper-byte write over pending command -> merge and overrun.
    applyStimulus(1'b1, 2'b10, 16'hAB00, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1);
    expectVal("be_merge", 16'hAB34);    checkOutput(snd_dout);
    expectVal("overrun_status", 16'h0005); checkOutput(st(main_status));
    idle(); step(1);

    applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b1, 16'h55AA, 1'b0);
    step(1);
    expectVal("reply_dout", 16'h55AA);  checkOutput(main_dout);
    expectVal("reply_irq", 16'h0001);   checkOutput(b1(main_irq));
    expectVal("reply_status", 16'h0007); checkOutput(st(main_status));
    idle(); step(1);

    applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1);
    expectVal("snd_rd_status", 16'h0006); checkOutput(st(main_status));
    expectVal("snd_rd_irq", 16'h0000);  checkOutput(b1(snd_irq));
    idle(); step(1);

    applyStimulus(1'b0, 2'b00, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    expectVal("main_rd_before", 16'h55AA); checkOutput(main_dout);
    step(1);
    expectVal("main_rd_status", 16'h0000); checkOutput(st(main_status));
    expectVal("main_rd_irq", 16'h0000);  checkOutput(b1(main_irq));
    idle(); step(1);

    // Write and sound read in the same cycle: write wins, no overrun.
    applyStimulus(1'b1, 2'b11, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1); idle(); step(1);
    applyStimulus(1'b1, 2'b11, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1);
    expectVal("sim_wr_rd_status", 16'h0001); checkOutput(st(main_status));
    expectVal("sim_wr_rd_latch", 16'h2222);  checkOutput(snd_dout);
    expectVal("sim_wr_rd_irq", 16'h0001);    checkOutput(b1(snd_irq));
    idle(); step(1);

    // Interrupt ack drops only snd_irq.
    applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1);
    expectVal("ack_irq", 16'h0000);     checkOutput(b1(snd_irq));
    expectVal("ack_status", 16'h0001);  checkOutput(st(main_status));
    idle(); step(1);
    applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1);
    expectVal("ack_then_rd", 16'h0000); checkOutput(st(main_status));
    idle(); step(1);

    // Reply write and main read in the same cycle: write wins.
    applyStimulus(1'b0, 2'b00, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0BEE, 1'b0);
    step(1);
    expectVal("sim_swr_rd_status", 16'h0002); checkOutput(st(main_status));
    expectVal("sim_swr_rd_dout", 16'h0BEE);   checkOutput(main_dout);
    expectVal("sim_swr_rd_irq", 16'h0001);    checkOutput(b1(main_irq));
    idle(); step(1);
    applyStimulus(1'b0, 2'b00, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1); idle(); step(1);

    // Sound reset clears the command side and defers a main write.
    applyStimulus(1'b1, 2'b11, 16'h3333, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1); idle(); step(1);
    snd_reset_n = 1'b0;
    step(1);
    expectVal("sres_status", 16'h0000); checkOutput(st(main_status));
    expectVal("sres_irq", 16'h0000);    checkOutput(b1(snd_irq));
    expectVal("sres_latch", 16'h3333);  checkOutput(snd_dout);
    applyStimulus(1'b1, 2'b11, 16'h0042, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1);
    expectVal("sres_deferred", 16'h3333); checkOutput(snd_dout);
    idle(); step(1);
    snd_reset_n = 1'b1;
    expectVal("sres_release_same", 16'h0000); checkOutput(st(main_status));
    step(1);
    expectVal("sres_after_status", 16'h0001); checkOutput(st(main_status));
    expectVal("sres_after_latch", 16'h0042);  checkOutput(snd_dout);
    expectVal("sres_after_irq", 16'h0001);    checkOutput(b1(snd_irq));

    // Asynchronous reset mid-operation.
    applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b1, 16'h7777, 1'b0);
    step(1); idle();
    expectVal("pre_areset_status", 16'h0003); checkOutput(st(main_status));
    #2 reset_n = 1'b0;
    #1;
    expectVal("areset_status", 16'h0000);   checkOutput(st(main_status));
    expectVal("areset_main_dout", 16'h0000); checkOutput(main_dout);
    expectVal("areset_snd_dout", 16'h0000);  checkOutput(snd_dout);
    expectVal("areset_irqs", 16'h0000);      checkOutput({14'b0, main_irq, snd_irq});
    step(1);
    reset_n = 1'b1;
    step(1);

    if (sb.size() != 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
